// File: rtl/uart_io_bridge.sv
// CPU I/O register bridge in front of uart_controller: DATA/STATUS/IRQ_EN/IRQ_PEND
// registers, tx back-pressure with optional timeout, and a level interrupt.
`timescale 1ns/1ps
module uart_io_bridge #(
    parameter int WR_TIMEOUT   = 1024,
    parameter int GUARD_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        io_cs,
    input  logic [1:0]  io_addr,
    input  logic        io_wr,
    input  logic        io_rd,
    input  logic [15:0] io_wdata,
    output logic [15:0] io_rdata,
    output logic        io_ready,
    output logic        irq,
    output logic        uart_wr_en,
    output logic [15:0] uart_data,
    output logic        uart_rd,
    input  logic [7:0]  uart_rx_data,
    input  logic [7:0]  uart_status
);

    localparam int GUARD_N = (GUARD_CYCLES < 2) ? 2 : GUARD_CYCLES;
    localparam int CNT_W   = (WR_TIMEOUT < 2) ? 1 : $clog2(WR_TIMEOUT);
    localparam int GCNT_W  = $clog2(GUARD_N);
    localparam bit HAS_TIMEOUT = (WR_TIMEOUT != 0);
    localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'((WR_TIMEOUT == 0) ? 0 : WR_TIMEOUT - 1);
    localparam logic [GCNT_W-1:0] GUARD_LAST = GCNT_W'(GUARD_N - 1);

    localparam logic [1:0] ADDR_DATA     = 2'd0;
    localparam logic [1:0] ADDR_STATUS   = 2'd1;
    localparam logic [1:0] ADDR_IRQ_EN   = 2'd2;
    localparam logic [1:0] ADDR_IRQ_PEND = 2'd3;

    typedef enum logic [2:0] {
        IDLE,
        WR_WAIT,
        WR_STROBE,
        RD_POP,
        RESP,
        GUARD
    } state_t;

    state_t              state;
    logic [CNT_W-1:0]    wait_cnt;
    logic [GCNT_W-1:0]   guard_cnt;
    logic                strobed;
    logic [2:0]          irq_en;
    logic [2:0]          irq_pend;
    logic                rx_avail_q;
    logic                tx_empty_q;

    logic                req;
    logic                timeout_hit;
    logic [2:0]          pend_set;
    logic [2:0]          pend_clr;

    assign req         = io_cs & (io_wr | io_rd);
    assign timeout_hit = HAS_TIMEOUT && (state == WR_WAIT) && !uart_status[0]
                         && (wait_cnt == CNT_LAST);
    assign pend_set    = {timeout_hit,
                          uart_status[1] & ~tx_empty_q,
                          uart_status[2] & ~rx_avail_q};
    assign pend_clr    = (state == IDLE && req && io_wr && io_addr == ADDR_IRQ_PEND)
                         ? io_wdata[2:0] : 3'b000;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            io_rdata   <= 16'h0000;
            io_ready   <= 1'b0;
            uart_wr_en <= 1'b0;
            uart_data  <= 16'h0000;
            uart_rd    <= 1'b0;
            irq_en     <= 3'b000;
            wait_cnt   <= '0;
            guard_cnt  <= '0;
            strobed    <= 1'b0;
        end else begin
            io_ready   <= 1'b0;
            uart_wr_en <= 1'b0;
            uart_rd    <= 1'b0;
            case (state)
                IDLE: begin
                    if (req) begin
                        strobed <= 1'b0;
                        state   <= RESP;
                        if (io_wr) begin
                            if (io_addr == ADDR_DATA) begin
                                if (uart_status[0]) begin
                                    state      <= WR_STROBE;
                                    uart_wr_en <= 1'b1;
                                    uart_data  <= io_wdata;
                                    strobed    <= 1'b1;
                                end else begin
                                    state    <= WR_WAIT;
                                    wait_cnt <= '0;
                                end
                            end else if (io_addr == ADDR_IRQ_EN) begin
                                irq_en <= io_wdata[2:0];
                            end
                        end else begin
                            case (io_addr)
                                ADDR_DATA: begin
                                    if (uart_status[2]) begin
                                        io_rdata <= {8'h00, uart_rx_data};
                                        state    <= RD_POP;
                                        uart_rd  <= 1'b1;
                                        strobed  <= 1'b1;
                                    end else begin
                                        io_rdata <= 16'h0000;
                                    end
                                end
                                ADDR_STATUS: io_rdata <= {8'h00, uart_status};
                                ADDR_IRQ_EN: io_rdata <= {13'h0000, irq_en};
                                default:     io_rdata <= {13'h0000, irq_pend};
                            endcase
                        end
                    end
                end
                WR_WAIT: begin
                    if (uart_status[0]) begin
                        state      <= WR_STROBE;
                        uart_wr_en <= 1'b1;
                        uart_data  <= io_wdata;
                        strobed    <= 1'b1;
                    end else if (timeout_hit) begin
                        state    <= RESP;
                        io_ready <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                WR_STROBE, RD_POP: begin
                    state    <= RESP;
                    io_ready <= 1'b1;
                end
                RESP: begin
                    // Register accesses arrive here with io_ready still low and
                    // spend one extra cycle so every access completes in two.
                    if (!io_ready) begin
                        io_ready <= 1'b1;
                    end else begin
                        state     <= strobed ? GUARD : IDLE;
                        guard_cnt <= '0;
                    end
                end
                GUARD: begin
                    if (guard_cnt == GUARD_LAST) begin
                        state <= IDLE;
                    end else begin
                        guard_cnt <= guard_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // A set arriving in the same cycle as a write-1-to-clear wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_pend   <= 3'b000;
            rx_avail_q <= 1'b0;
            tx_empty_q <= 1'b0;
            irq        <= 1'b0;
        end else begin
            rx_avail_q <= uart_status[2];
            tx_empty_q <= uart_status[1];
            irq_pend   <= (irq_pend & ~pend_clr) | pend_set;
            irq        <= |(irq_pend & irq_en);
        end
    end

endmodule

// File: tb/tb_uart_io_bridge.sv
// Directed plus randomized bench for uart_io_bridge against a transaction-level
// model of the register map and the interrupt pending/enable rules.
`timescale 1ns/1ps
module tb_uart_io_bridge;

    localparam int TO = 16;
    localparam int GC = 2;

    logic        clk;
    logic        rst_n;
    logic        io_cs;
    logic [1:0]  io_addr;
    logic        io_wr;
    logic        io_rd;
    logic [15:0] io_wdata;
    logic [15:0] io_rdata;
    logic        io_ready;
    logic        irq;
    logic        uart_wr_en;
    logic [15:0] uart_data;
    logic        uart_rd;
    logic [7:0]  uart_rx_data;
    logic [7:0]  uart_status;

    int vectors     = 0;
    int miscompares = 0;

    logic [2:0] mpend    = 3'b000;
    logic [2:0] men      = 3'b000;
    logic [7:0] mprev    = 8'h00;
    logic [2:0] m_clr    = 3'b000;
    logic [2:0] m_set    = 3'b000;
    logic       m_en_wr  = 1'b0;
    logic [2:0] m_en_val = 3'b000;

    uart_io_bridge #(.WR_TIMEOUT(TO), .GUARD_CYCLES(GC)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .io_cs        (io_cs),
        .io_addr      (io_addr),
        .io_wr        (io_wr),
        .io_rd        (io_rd),
        .io_wdata     (io_wdata),
        .io_rdata     (io_rdata),
        .io_ready     (io_ready),
        .irq          (irq),
        .uart_wr_en   (uart_wr_en),
        .uart_data    (uart_data),
        .uart_rd      (uart_rd),
        .uart_rx_data (uart_rx_data),
        .uart_status  (uart_status)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed no finish, expected finish before 2ms");
        $fatal(1, "watchdog");
    end

    task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // One clock: pending/enable/irq rules applied to the inputs seen at the edge.
    task automatic tick();
        logic [2:0] nxt_pend;
        logic [2:0] nxt_en;
        logic [7:0] nxt_prev;
        logic       exp_irq;
        if (!rst_n) begin
            nxt_pend = 3'b000;
            nxt_en   = 3'b000;
            nxt_prev = 8'h00;
            exp_irq  = 1'b0;
        end else begin
            exp_irq  = |(mpend & men);
            nxt_pend = (mpend & ~m_clr) | m_set
                       | {1'b0, uart_status[1] & ~mprev[1], uart_status[2] & ~mprev[2]};
            nxt_en   = m_en_wr ? m_en_val : men;
            nxt_prev = uart_status;
        end
        @(posedge clk);
        #1;
        mpend   = nxt_pend;
        men     = nxt_en;
        mprev   = nxt_prev;
        m_clr   = 3'b000;
        m_set   = 3'b000;
        m_en_wr = 1'b0;
        chk1("irq", irq, exp_irq);
    endtask

    // Full transaction issued from IDLE, then drained back to IDLE.
    task automatic xact(input string tag, input logic wr, input logic rd, input logic [1:0] addr,
                        input logic [15:0] wdata, input logic [7:0] st, input logic [7:0] rx);
        logic        exp_wr;
        logic        exp_rd;
        logic [15:0] exp_rdata;
        exp_wr = wr && (addr == 2'd0);
        exp_rd = !wr && rd && (addr == 2'd0) && st[2];
        case (addr)
            2'd0:    exp_rdata = st[2] ? {8'h00, rx} : 16'h0000;
            2'd1:    exp_rdata = {8'h00, st};
            2'd2:    exp_rdata = {13'h0000, men};
            default: exp_rdata = {13'h0000, mpend};
        endcase
        if (wr && addr == 2'd2) begin
            m_en_wr  = 1'b1;
            m_en_val = wdata[2:0];
        end
        if (wr && addr == 2'd3) m_clr = wdata[2:0];
        uart_status  = st;
        uart_rx_data = rx;
        io_addr      = addr;
        io_wdata     = wdata;
        io_wr        = wr;
        io_rd        = rd;
        io_cs        = 1'b1;
        tick();
        chk1({tag, "/wr_en1"}, uart_wr_en, exp_wr);
        chk1({tag, "/rd1"}, uart_rd, exp_rd);
        chk1({tag, "/ready1"}, io_ready, 1'b0);
        if (exp_wr) chk16({tag, "/data"}, uart_data, wdata);
        tick();
        chk1({tag, "/ready2"}, io_ready, 1'b1);
        chk1({tag, "/wr_en2"}, uart_wr_en, 1'b0);
        chk1({tag, "/rd2"}, uart_rd, 1'b0);
        if (!wr) chk16({tag, "/rdata"}, io_rdata, exp_rdata);
        io_cs = 1'b0;
        io_wr = 1'b0;
        io_rd = 1'b0;
        tick();
        chk1({tag, "/ready3"}, io_ready, 1'b0);
        if (exp_wr || exp_rd) repeat (GC) tick();
    endtask

    initial begin
        int n;
        rst_n        = 1'b0;
        io_cs        = 1'b0;
        io_addr      = 2'd0;
        io_wr        = 1'b0;
        io_rd        = 1'b0;
        io_wdata     = 16'h0000;
        uart_rx_data = 8'h00;
        uart_status  = 8'h03;
        repeat (3) tick();
        chk16("rst/rdata", io_rdata, 16'h0000);
        chk16("rst/uart_data", uart_data, 16'h0000);
        chk1("rst/ready", io_ready, 1'b0);
        chk1("rst/wr_en", uart_wr_en, 1'b0);
        chk1("rst/rd", uart_rd, 1'b0);
        rst_n = 1'b1;
        tick();

        // Write with space, then a STATUS read queued behind it waits out the guard.
        io_cs = 1'b1; io_wr = 1'b1; io_rd = 1'b0; io_addr = 2'd0; io_wdata = 16'h0041;
        tick();
        chk1("w41/wr_en", uart_wr_en, 1'b1);
        chk16("w41/data", uart_data, 16'h0041);
        chk1("w41/ready1", io_ready, 1'b0);
        tick();
        chk1("w41/ready2", io_ready, 1'b1);
        chk1("w41/wr_en2", uart_wr_en, 1'b0);
        io_wr = 1'b0; io_rd = 1'b1; io_addr = 2'd1;
        n = 0;
        do begin tick(); n++; end while (!io_ready && n < 32);
        chk16("guard_lat", 16'(n), 16'(3 + GC));
        chk16("guard_rdata", io_rdata, 16'h0003);
        io_cs = 1'b0; io_rd = 1'b0;
        tick();
        io_cs = 1'b1; io_rd = 1'b1; io_addr = 2'd1;
        tick(); tick();
        chk1("st_ready", io_ready, 1'b1);
        io_addr = 2'd2;
        n = 0;
        do begin tick(); n++; end while (!io_ready && n < 32);
        chk16("noguard_lat", 16'(n), 16'd3);
        chk16("noguard_rdata", io_rdata, {13'h0000, men});
        io_cs = 1'b0; io_rd = 1'b0;
        tick();

        // Full tx FIFO for 10 cycles, then space appears.
        uart_status = 8'h02;
        io_cs = 1'b1; io_wr = 1'b1; io_addr = 2'd0; io_wdata = 16'h1234;
        tick();
        chk1("full/wr_en0", uart_wr_en, 1'b0);
        for (int i = 1; i < 10; i++) begin
            tick();
            chk1("full/wr_en", uart_wr_en, 1'b0);
            chk1("full/ready", io_ready, 1'b0);
        end
        uart_status = 8'h03;
        tick();
        chk1("full/strobe", uart_wr_en, 1'b1);
        chk16("full/data", uart_data, 16'h1234);
        tick();
        chk1("full/done", io_ready, 1'b1);
        io_cs = 1'b0; io_wr = 1'b0;
        tick();
        repeat (GC) tick();

        // Write timeout with tx never ready.
        uart_status = 8'h00;
        tick();
        xact("clr_pre_to", 1'b1, 1'b0, 2'd3, 16'h0007, 8'h00, 8'h00);
        io_cs = 1'b1; io_wr = 1'b1; io_addr = 2'd0; io_wdata = 16'h0099;
        tick();
        for (int i = 1; i < TO; i++) begin
            tick();
            chk1("to/ready", io_ready, 1'b0);
            chk1("to/wr_en", uart_wr_en, 1'b0);
        end
        m_set = 3'b100;
        tick();
        chk1("to/ready_end", io_ready, 1'b1);
        chk1("to/no_strobe", uart_wr_en, 1'b0);
        io_cs = 1'b0; io_wr = 1'b0;
        tick();
        xact("pend_to", 1'b0, 1'b1, 2'd3, 16'h0000, 8'h00, 8'h00);
        chk16("pend_to_val", io_rdata, 16'h0004);

        // Interrupt enable, rising rx_avail, clear, and clear racing a new edge.
        xact("clr_all", 1'b1, 1'b0, 2'd3, 16'h0007, 8'h01, 8'h00);
        xact("en_wr", 1'b1, 1'b0, 2'd2, 16'hFFF9, 8'h01, 8'h00);
        xact("en_rd", 1'b0, 1'b1, 2'd2, 16'h0000, 8'h01, 8'h00);
        chk16("en_val", io_rdata, 16'h0001);
        uart_status = 8'h05;
        tick();
        tick();
        chk1("irq_rise", irq, 1'b1);
        xact("clr_rx", 1'b1, 1'b0, 2'd3, 16'h0001, 8'h05, 8'h00);
        chk1("irq_fall", irq, 1'b0);
        uart_status = 8'h01; tick();
        uart_status = 8'h05; tick();
        uart_status = 8'h01; tick();
        xact("clr_vs_rise", 1'b1, 1'b0, 2'd3, 16'h0001, 8'h05, 8'h00);
        xact("pend_race", 1'b0, 1'b1, 2'd3, 16'h0000, 8'h05, 8'h00);
        chk16("pend_race_bit0", {15'h0000, io_rdata[0]}, 16'h0001);
        chk1("irq_race", irq, 1'b1);

        // DATA reads and simultaneous write/read.
        xact("rd_5a", 1'b0, 1'b1, 2'd0, 16'h0000, 8'h05, 8'h5A);
        xact("rd_empty", 1'b0, 1'b1, 2'd0, 16'h0000, 8'h01, 8'hA5);
        xact("wr_rd", 1'b1, 1'b1, 2'd0, 16'h00C3, 8'h07, 8'h77);

        for (int k = 0; k < 40; k++) begin
            logic [7:0]  st;
            logic [7:0]  rx;
            logic [15:0] wd;
            int          op;
            st = 8'($urandom);
            rx = 8'($urandom);
            wd = 16'($urandom);
            op = int'($urandom_range(0, 7));
            case (op)
                0: xact("rnd_st_rd", 1'b0, 1'b1, 2'd1, wd, st, rx);
                1: xact("rnd_en_wr", 1'b1, 1'b0, 2'd2, wd, st, rx);
                2: xact("rnd_en_rd", 1'b0, 1'b1, 2'd2, wd, st, rx);
                3: xact("rnd_pend_rd", 1'b0, 1'b1, 2'd3, wd, st, rx);
                4: xact("rnd_pend_wr", 1'b1, 1'b0, 2'd3, wd, st, rx);
                5: xact("rnd_data_rd", 1'b0, 1'b1, 2'd0, wd, st, rx);
                6: begin
                    st[0] = 1'b1;
                    xact("rnd_data_wr", 1'b1, st[3], 2'd0, wd, st, rx);
                end
                default: xact("rnd_st_wr", 1'b1, 1'b0, 2'd1, wd, st, rx);
            endcase
        end

        // Reset while a write is stalled in the wait state.
        uart_status = 8'h00;
        io_cs = 1'b1; io_wr = 1'b1; io_rd = 1'b0; io_addr = 2'd0; io_wdata = 16'hBEEF;
        tick(); tick(); tick();
        chk1("rw/ready", io_ready, 1'b0);
        chk1("rw/wr_en", uart_wr_en, 1'b0);
        rst_n = 1'b0;
        #1;
        chk16("rw_rst/rdata", io_rdata, 16'h0000);
        chk16("rw_rst/uart_data", uart_data, 16'h0000);
        chk1("rw_rst/ready", io_ready, 1'b0);
        chk1("rw_rst/irq", irq, 1'b0);
        chk1("rw_rst/wr_en", uart_wr_en, 1'b0);
        chk1("rw_rst/rd", uart_rd, 1'b0);
        io_cs = 1'b0; io_wr = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        tick();
        chk1("post_rst/wr_en", uart_wr_en, 1'b0);
        xact("post_rst_st", 1'b0, 1'b1, 2'd1, 16'h0000, 8'h5C, 8'h00);
        xact("post_rst_en", 1'b0, 1'b1, 2'd2, 16'h0000, 8'h5C, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
